// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
// Data requests win by default; a saturating starvation counter forces a fetch grant.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_owner_d;
    logic       r_we;
    logic [3:0] r_starve;
    logic [2:0] r_wait;

    logic w_any_req;
    logic w_starved;
    logic w_grant_f;

    assign w_any_req = if_req || d_req;
    assign w_starved = (r_starve == 4'(STARVE_MAX));
    // Fetch only beats a pending data request once it has been passed over STARVE_MAX times.
    assign w_grant_f = if_req && (!d_req || w_starved);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_starve  <= 4'd0;
            r_wait    <= 3'd0;
            if_ack    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state  <= ISSUE;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_addr <= w_grant_f ? if_addr : d_addr;
                        if (w_grant_f) begin
                            r_owner_d <= 1'b0;
                            r_we      <= 1'b0;
                            if_ack    <= 1'b1;
                            r_starve  <= 4'd0;
                        end else begin
                            r_owner_d <= 1'b1;
                            r_we      <= d_we;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            d_ack     <= 1'b1;
                            if (if_req && !w_starved) begin
                                r_starve <= r_starve + 4'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= WAIT;
                        r_wait  <= 3'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    // mem_rdata becomes valid in the final WAIT cycle; capture it on that edge.
                    if (r_wait == 3'd0) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        if (r_owner_d) begin
                            d_rdata  <= mem_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Main instance at MEM_LAT=2 plus fetch-only instances at MEM_LAT=1 and MEM_LAT=7.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, d_req, d_we, x_if_req;
    logic [31:0] if_addr, d_addr, d_wdata, x_if_addr;

    logic        if_ack[3], if_rvalid[3], d_ack[3], d_rvalid[3], m_en[3], m_we[3], busy[3];
    logic [31:0] if_rdata[3], d_rdata[3], m_addr[3], m_wdata[3], m_rdata[3];
    logic [31:0] pipe[3][8];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q_if[$];
    exp_t q_d[$];
    exp_t mon_e;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_rv;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h40) ? 32'h1234ABCD : {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: data for an enabled address appears LAT cycles after the enable cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 7; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
            pipe[k][0] <= m_en[k] ? mem_f(m_addr[k]) : (32'hBAD00000 ^ 32'(cyc));
        end
    end
    assign m_rdata[0] = pipe[0][LAT-1];
    assign m_rdata[1] = pipe[1][0];
    assign m_rdata[2] = pipe[2][6];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[0]), .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]),
        .mem_rdata(m_rdata[0]), .busy(busy[0])
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(x_if_req), .if_addr(x_if_addr), .if_ack(if_ack[1]), .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(d_ack[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]),
        .mem_rdata(m_rdata[1]), .busy(busy[1])
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(7), .STARVE_MAX(4)) u_lat7 (
        .clk(clk), .rst(rst),
        .if_req(x_if_req), .if_addr(x_if_addr), .if_ack(if_ack[2]), .if_rvalid(if_rvalid[2]), .if_rdata(if_rdata[2]),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(d_ack[2]), .d_rvalid(d_rvalid[2]), .d_rdata(d_rdata[2]),
        .mem_en(m_en[2]), .mem_we(m_we[2]), .mem_addr(m_addr[2]), .mem_wdata(m_wdata[2]),
        .mem_rdata(m_rdata[2]), .busy(busy[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every rvalid on the main instance must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (if_rvalid[0]) begin
                chk1("if_rvalid_expected", q_if.size() != 0, 1'b1);
                if (q_if.size() != 0) begin
                    mon_e = q_if.pop_front();
                    chk("if_rdata", if_rdata[0], mon_e.data);
                    chk("if_rvalid_cycle", cyc, mon_e.cyc);
                end
            end
            if (d_rvalid[0]) begin
                chk1("d_rvalid_expected", q_d.size() != 0, 1'b1);
                if (q_d.size() != 0) begin
                    mon_e = q_d.pop_front();
                    chk("d_rdata", d_rdata[0], mon_e.data);
                    chk("d_rvalid_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk1({tag, "_if_ack"}, if_ack[0], 1'b0);
        chk1({tag, "_if_rvalid"}, if_rvalid[0], 1'b0);
        chk({tag, "_if_rdata"}, if_rdata[0], 32'h0);
        chk1({tag, "_d_ack"}, d_ack[0], 1'b0);
        chk1({tag, "_d_rvalid"}, d_rvalid[0], 1'b0);
        chk({tag, "_d_rdata"}, d_rdata[0], 32'h0);
        chk1({tag, "_mem_en"}, m_en[0], 1'b0);
        chk1({tag, "_mem_we"}, m_we[0], 1'b0);
        chk({tag, "_mem_addr"}, m_addr[0], 32'h0);
        chk({tag, "_mem_wdata"}, m_wdata[0], 32'h0);
        chk1({tag, "_busy"}, busy[0], 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk1("idle_reached", busy[0], 1'b0);
    endtask

    task automatic wait_ack(input bit is_d, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_ack[0] : if_ack[0]) && n < limit);
    endtask

    task automatic run_txn(input vec_t v);
        int   t0;
        exp_t e;
        t0 = cyc;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        if (v.exp_rv) begin
            e.data = v.exp_rdata;
            e.cyc  = t0 + 2 + LAT;
            if (v.is_d) q_d.push_back(e);
            else q_if.push_back(e);
        end
        wait_ack(v.is_d, 20);
        chk("ack_cycle", cyc, t0 + 1);
        chk1("mem_en_issue", m_en[0], 1'b1);
        chk1("mem_we_issue", m_we[0], v.we);
        chk("mem_addr_issue", m_addr[0], v.addr);
        if (v.is_d && v.we) chk("mem_wdata_issue", m_wdata[0], v.wdata);
        chk1("other_ack_low", v.is_d ? if_ack[0] : d_ack[0], 1'b0);
        chk1("busy_issue", busy[0], 1'b1);
        if_req = 1'b0; d_req = 1'b0;
        if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
        @(negedge clk);
        chk1("mem_en_after", m_en[0], 1'b0);
        chk1("mem_we_after", m_we[0], 1'b0);
        chk("mem_addr_hold", m_addr[0], v.addr);
        wait_idle();
        chk("idle_cycle", cyc, v.exp_rv ? t0 + 2 + LAT : t0 + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int       t0, n, ng, acks, got1, got7;
        exp_t     e;
        bit [9:0] got_f;
        bit [9:0] exp_f;

        vecs[0] = '{1'b0, 1'b0, 32'h00000040, 32'h0, 1'b1, 32'h1234ABCD};
        vecs[1] = '{1'b1, 1'b1, 32'h00000080, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h00000080, 32'h0, 1'b1, 32'h0080FF7F};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'hFFFC0003};
        vecs[4] = '{1'b1, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'hA5A55A5A, 32'h0, 1'b1, 32'h5A5AA5A5};
        vecs[6] = '{1'b0, 1'b0, 32'h00001000, 32'h0, 1'b1, 32'h1000EFFF};
        vecs[7] = '{1'b1, 1'b1, 32'h7FFFFFFF, 32'h12345678, 1'b0, 32'h0};

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        x_if_req = 1'b0; x_if_addr = 32'h0;
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);
        chk("if_rdata_hold", if_rdata[0], 32'h1000EFFF);
        chk("d_rdata_hold", d_rdata[0], 32'h5A5AA5A5);

        // Data request raised and dropped while a fetch is in WAIT must never be granted.
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h300;
        e.data = 32'h0300FCFF; e.cyc = t0 + 2 + LAT; q_if.push_back(e);
        wait_ack(1'b0, 20);
        chk("drop_if_ack_cycle", cyc, t0 + 1);
        if_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        @(negedge clk);
        d_req = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (d_ack[0]) acks++;
        end
        chk("dropped_req_acks", acks, 0);

        // Simultaneous requests with an empty starvation count: data first, fetch next IDLE.
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        e.data = 32'h0080FF7F; e.cyc = t0 + 2 + LAT; q_d.push_back(e);
        e.data = 32'h1234ABCD; e.cyc = t0 + 4 + 2 * LAT; q_if.push_back(e);
        wait_ack(1'b1, 20);
        chk("both_d_ack_cycle", cyc, t0 + 1);
        chk1("both_if_ack_low", if_ack[0], 1'b0);
        d_req = 1'b0;
        wait_ack(1'b0, 30);
        chk("both_if_ack_cycle", cyc, t0 + 3 + LAT);
        if_req = 1'b0;
        wait_idle();

        // Both requesters held high: starvation limit forces every fifth grant to fetch.
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        ng = 0; n = 0; got_f = '0;
        exp_f = 10'b1000010000;
        while (ng < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (if_ack[0] || d_ack[0]) begin
                chk1("single_ack", if_ack[0] & d_ack[0], 1'b0);
                got_f[ng] = if_ack[0];
                e.cyc = cyc + 1 + LAT;
                if (if_ack[0]) begin e.data = mem_f(32'h100); q_if.push_back(e); end
                else begin e.data = mem_f(32'h200); q_d.push_back(e); end
                ng++;
                if (ng == 10) begin if_req = 1'b0; d_req = 1'b0; end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("grant_count", ng, 10);
        for (int i = 0; i < 10; i++) chk1($sformatf("grant_%0d_is_fetch", i), got_f[i], exp_f[i]);
        wait_idle();

        // Reset in the second WAIT cycle of a fetch aborts it silently.
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        e.data = 32'h1234ABCD; e.cyc = t0 + 2 + LAT; q_if.push_back(e);
        wait_ack(1'b0, 20);
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("busy_before_reset", busy[0], 1'b1);
        rst = 1'b0;
        #1 check_all_zero("abort");
        q_if.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        run_txn(vecs[0]);

        // Latency extremes on the side instances.
        t0 = cyc;
        x_if_req = 1'b1; x_if_addr = 32'h40;
        got1 = -1; got7 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_ack[1]) x_if_req = 1'b0;
            if (if_rvalid[1]) begin got1 = cyc; chk("lat1_rdata", if_rdata[1], 32'h1234ABCD); end
            if (if_rvalid[2]) begin got7 = cyc; chk("lat7_rdata", if_rdata[2], 32'h1234ABCD); end
        end
        x_if_req = 1'b0;
        chk("lat1_rvalid_cycle", got1, t0 + 3);
        chk("lat7_rvalid_cycle", got7, t0 + 9);

        repeat (12) @(negedge clk);
        chk("if_queue_drained", q_if.size(), 0);
        chk("d_queue_drained", q_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
